// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder slice.
// Holds the default operand width and a sign-based overflow reference
// function used by benches and other consumers that want a golden model.
package rca_pkg;

  localparam int unsigned RCA_DEFAULT_WIDTH = 32;

  // Signed overflow from operand/result sign bits: same-sign operands
  // producing a result of the opposite sign.
  function automatic logic rca_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple carry chain.
// Ports:
//   a, b  - operand bits
//   cin   - carry into this bit
//   s     - sum bit
//   cout  - carry out of this bit
module full_adder
  import rca_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit two's-complement ripple-carry adder with combinational and
// registered (1-cycle latency) results.
// Optional feature: define RCA_STICKY_OVF_EN to add a sticky overflow flag
// with a synchronous clear (ports ovf_clr / ovf_sticky).
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   a, b, cin            - signed operands and carry-in
//   sum, cout, overflow  - combinational result, carry-out, signed overflow
//   sum_q, cout_q,
//   overflow_q           - registered copies of the above
//   ovf_clr              - clears the sticky flag (optional)
//   ovf_sticky           - sticky overflow flag (optional)
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             overflow_q
`ifdef RCA_STICKY_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // Carry chain of single-bit cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign cout     = carry[WIDTH];
  assign overflow = carry[WIDTH] ^ carry[WIDTH-1];

  // Output register stage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef RCA_STICKY_OVF_EN
      ovf_sticky <= 1'b0;
`endif
    end else begin
      sum_q      <= sum;
      cout_q     <= cout;
      overflow_q <= overflow;
`ifdef RCA_STICKY_OVF_EN
      // Clear has priority over a coincident overflow.
      ovf_sticky <= ovf_clr ? 1'b0 : (ovf_sticky | overflow);
`endif
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder (WIDTH=32): stimulus pushes
// expected results from an arithmetic reference model, a monitor checks
// combinational outputs mid-cycle and registered outputs after each edge.
module tb_ripple_carry_adder;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic [W-1:0] sum_q;
  logic         cout_q;
  logic         overflow_q;
  logic         ovf_clr;
`ifdef RCA_STICKY_OVF_EN
  logic         ovf_sticky;
`endif

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .sum        (sum),
    .cout       (cout),
    .overflow   (overflow),
    .sum_q      (sum_q),
    .cout_q     (cout_q),
    .overflow_q (overflow_q)
`ifdef RCA_STICKY_OVF_EN
    ,
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         sticky;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic model_sticky = 1'b0;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h (a=0x%08h b=0x%08h cin=%0d) t=%0t",
               name, got, exp, a, b, cin, $time);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic at wider precision.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc);
    exp_t        m;
    logic [W:0]  full;
    longint      s;
    full   = (W+1)'(ta) + (W+1)'(tb) + (W+1)'(tc);
    s      = longint'($signed(ta)) + longint'($signed(tb)) + longint'(tc);
    m.a    = ta;
    m.b    = tb;
    m.cin  = tc;
    m.sum  = full[W-1:0];
    m.cout = full[W];
    m.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    m.sticky = 1'b0;
    return m;
  endfunction

  // Drive one vector (caller aligns to negedge) and queue its expectation.
  task automatic apply(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic clr);
    exp_t e;
    a       = ta;
    b       = tb;
    cin     = tc;
    ovf_clr = clr;
    e = model(ta, tb, tc);
    model_sticky = clr ? 1'b0 : (model_sticky | e.ovf);
    e.sticky = model_sticky;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_q_zero(input string tag);
    chk({tag, "_sum_q"}, sum_q, '0);
    chk({tag, "_cout_q"}, W'(cout_q), '0);
    chk({tag, "_ovf_q"}, W'(overflow_q), '0);
`ifdef RCA_STICKY_OVF_EN
    chk({tag, "_sticky"}, W'(ovf_sticky), '0);
`endif
  endtask

  // Monitor: combinational check mid-cycle, registered check after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #10;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("comb_sum", sum, e.sum);
        chk("comb_cout", W'(cout), W'(e.cout));
        chk("comb_ovf", W'(overflow), W'(e.ovf));
      end
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("reg_sum_q", sum_q, e.sum);
        chk("reg_cout_q", W'(cout_q), W'(e.cout));
        chk("reg_ovf_q", W'(overflow_q), W'(e.ovf));
`ifdef RCA_STICKY_OVF_EN
        chk("reg_sticky", W'(ovf_sticky), W'(e.sticky));
`endif
      end
    end
  end

  logic [W-1:0] edge_vals [5];

  function automatic logic [W-1:0] pick();
    int unsigned k;
    k = $urandom_range(0, 7);
    return (k < 5) ? edge_vals[k] : W'($urandom);
  endfunction

  initial begin
    edge_vals[0] = 32'h0000_0000;
    edge_vals[1] = 32'h0000_0001;
    edge_vals[2] = 32'h7FFF_FFFF;
    edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'hFFFF_FFFF;

    a = '0; b = '0; cin = 1'b0; ovf_clr = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3 chk_q_zero("rst_init");

    // Nonzero inputs while reset is held: registers must stay cleared.
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0;
    #60 chk_q_zero("rst_hold");

    // Release reset and apply 5+7 in the same negedge.
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'd5, 32'd7, 1'b0, 1'b0);
    #10 chk("pre_edge_sum_q", sum_q, '0);
    chk("pre_edge_comb_sum", sum, 32'd12);

    // Directed cases.
    @(negedge clk) apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(negedge clk) apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk) apply(32'd100, -32'sd50, 1'b0, 1'b0);
    @(negedge clk) apply(32'd12345, 32'd54321, 1'b0, 1'b0);
    @(negedge clk) apply(-32'sd12345, -32'sd54321, 1'b0, 1'b0);
    @(negedge clk) apply(32'd123456, -32'sd654321, 1'b0, 1'b0);
    @(negedge clk) apply(32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk) apply(-32'sd100000, 32'd99999, 1'b0, 1'b0);
    @(negedge clk) apply(32'h7FFF_FFFE, 32'd0, 1'b1, 1'b0);
    @(negedge clk) apply(32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0);
    @(negedge clk) apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Sticky sequence: set, hold, clear, clear-vs-overflow.
    @(negedge clk) apply(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
    @(negedge clk) apply(32'd1, 32'd1, 1'b0, 1'b0);
    @(negedge clk) apply(32'd3, 32'd4, 1'b1, 1'b0);
    @(negedge clk) apply(32'd2, 32'd2, 1'b0, 1'b1);
    @(negedge clk) apply(32'd2, 32'd2, 1'b0, 1'b0);
    @(negedge clk) apply(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clk) apply(32'd9, 32'd9, 1'b0, 1'b0);

    // Randomized vectors biased towards boundary operands.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      apply(pick(), pick(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // Leave nonzero registered values, then reset mid-cycle.
    @(negedge clk) apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_drain();
    @(negedge clk);
    #5 rst_n = 1'b0;
    model_sticky = 1'b0;
    #1 chk_q_zero("rst_mid");

    // Combinational path is independent of reset.
    a = 32'd100; b = -32'sd50; cin = 1'b0;
    #10;
    chk("rst_comb_sum", sum, 32'd50);
    chk("rst_comb_cout", W'(cout), 32'd1);
    chk("rst_comb_ovf", W'(overflow), 32'd0);
    @(posedge clk);
    #1 chk_q_zero("rst_mid_hold");

    @(negedge clk);
    rst_n = 1'b1;
    apply(32'd5, 32'd7, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      apply(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
